// File: rtl/incrementer_pkg.sv
// Shared constants for the incrementer counter bank: default width, mode encodings
// and the all-ones helper used for overflow detection.
package incrementer_pkg;

    localparam int unsigned CNT_LEN_DEFAULT = 30;

    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    // Widths of 64 and above return a full 64-bit all-ones pattern.
    function automatic logic [63:0] all_ones(input int unsigned len);
        if (len >= 64) begin
            return '1;
        end
        return (64'd1 << len) - 64'd1;
    endfunction

endpackage

// File: rtl/incrementer_channel.sv
// One event counter with write/increment priority, wrap/saturate mode and a
// sticky overflow flag.
module incrementer_channel
    import incrementer_pkg::*;
#(
    parameter int LEN = CNT_LEN_DEFAULT
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           inc_i,
    input  logic           sat_mode_i,
    input  logic           wr_hit_i,
    input  logic [LEN-1:0] wr_data_i,
    input  logic           ovf_clr_i,
    output logic [LEN-1:0] count_o,
    output logic           ovf_o
);

    localparam logic [LEN-1:0] ONES = LEN'(all_ones(LEN));

    logic [LEN-1:0] count_q, count_d;
    logic           ovf_q, ovf_d;
    logic           ovf_evt;

    always_comb begin
        count_d = count_q;
        ovf_evt = 1'b0;
        if (wr_hit_i) begin
            count_d = wr_data_i;
        end else if (inc_i) begin
            if (count_q != ONES) begin
                count_d = count_q + LEN'(1);
            end else begin
                ovf_evt = 1'b1;
                count_d = (sat_mode_i == CNT_SAT) ? count_q : '0;
            end
        end
        // A new overflow beats a clear in the same cycle.
        ovf_d = ovf_evt | (ovf_q & ~ovf_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/incrementer_counter_bank.sv
// Bank of CHANNELS event counters with a registered read port.
// Optional overflow interrupt enabled by defining COUNTER_BANK_IRQ_EN.
module incrementer_counter_bank
    import incrementer_pkg::*;
#(
    parameter int LEN      = CNT_LEN_DEFAULT,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] inc_en,
    input  logic [CHANNELS-1:0] sat_mode,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic [LEN-1:0]      wr_data,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [LEN-1:0]      rd_data,
    output logic [CHANNELS-1:0] ovf,
    input  logic [CHANNELS-1:0] ovf_clr
`ifdef COUNTER_BANK_IRQ_EN
    ,
    input  logic [CHANNELS-1:0] irq_mask,
    output logic                irq
`endif
);

    logic [LEN-1:0] count [CHANNELS];
    logic [LEN-1:0] rd_data_q, rd_data_d;

    // Selects that match no channel simply produce no write hit.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        incrementer_channel #(
            .LEN(LEN)
        ) u_channel (
            .clk_i      (clk),
            .rst_n_i    (reset),
            .inc_i      (inc_en[g]),
            .sat_mode_i (sat_mode[g]),
            .wr_hit_i   (wr_en && (wr_sel == SEL_W'(g))),
            .wr_data_i  (wr_data),
            .ovf_clr_i  (ovf_clr[g]),
            .count_o    (count[g]),
            .ovf_o      (ovf[g])
        );
    end

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data_d = count[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

`ifdef COUNTER_BANK_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(ovf & irq_mask);
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_incrementer_counter_bank.sv
// Directed self-checking bench for incrementer_counter_bank (LEN=30, CHANNELS=4).
module tb_incrementer_counter_bank;

    localparam int LEN      = 30;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [CHANNELS-1:0] inc_en;
    logic [CHANNELS-1:0] sat_mode;
    logic                wr_en;
    logic [SEL_W-1:0]    wr_sel;
    logic [LEN-1:0]      wr_data;
    logic [SEL_W-1:0]    rd_sel;
    logic [LEN-1:0]      rd_data;
    logic [CHANNELS-1:0] ovf;
    logic [CHANNELS-1:0] ovf_clr;
`ifdef COUNTER_BANK_IRQ_EN
    logic [CHANNELS-1:0] irq_mask;
    logic                irq;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    incrementer_counter_bank #(
        .LEN      (LEN),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (inc_en),
        .sat_mode (sat_mode),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
`ifdef COUNTER_BANK_IRQ_EN
        ,
        .irq_mask (irq_mask),
        .irq      (irq)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ch(input logic [SEL_W-1:0] ch, input logic [LEN-1:0] val);
        wr_en   = 1'b1;
        wr_sel  = ch;
        wr_data = val;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if (rd_data !== '0) begin
            failures++;
            $display("FAIL reset_rd_data got=%h exp=%h", rd_data, 30'h0);
        end
        checks++;
        if (ovf !== '0) begin
            failures++;
            $display("FAIL reset_ovf got=%b exp=%b", ovf, 4'b0000);
        end
        tick();
        reset = 1'b1;
        inc_en = 4'b0001;
        repeat (5) tick();
        inc_en = '0;
        rd_sel = 2'd0;
        tick();
        checks++;
        if (rd_data !== 30'd5) begin
            failures++;
            $display("FAIL precount_ch0 got=%h exp=%h", rd_data, 30'd5);
        end
        // Mid-cycle asynchronous assertion
        #2 reset = 1'b0;
        #1;
        checks++;
        if (rd_data !== '0) begin
            failures++;
            $display("FAIL async_reset_rd_data got=%h exp=%h", rd_data, 30'h0);
        end
        checks++;
        if (ovf !== '0) begin
            failures++;
            $display("FAIL async_reset_ovf got=%b exp=%b", ovf, 4'b0000);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (rd_data !== '0) begin
            failures++;
            $display("FAIL after_reset_ch0 got=%h exp=%h", rd_data, 30'h0);
        end
    endtask

    task automatic test_wrap();
        sat_mode[1] = 1'b0;
        write_ch(2'd1, 30'h3FFF_FFFE);
        inc_en = 4'b0010;
        tick();
        checks++;
        if (ovf[1] !== 1'b0) begin
            failures++;
            $display("FAIL wrap_ovf_early got=%b exp=%b", ovf[1], 1'b0);
        end
        tick();
        checks++;
        if (ovf[1] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_ovf_set got=%b exp=%b", ovf[1], 1'b1);
        end
        inc_en = '0;
        rd_sel = 2'd1;
        tick();
        checks++;
        if (rd_data !== 30'h0) begin
            failures++;
            $display("FAIL wrap_value got=%h exp=%h", rd_data, 30'h0);
        end
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = '0;
        checks++;
        if (ovf[1] !== 1'b0) begin
            failures++;
            $display("FAIL wrap_ovf_clr got=%b exp=%b", ovf[1], 1'b0);
        end
    endtask

    task automatic test_saturate();
        sat_mode[2] = 1'b1;
        write_ch(2'd2, 30'h3FFF_FFFF);
        inc_en = 4'b0100;
        tick();
        checks++;
        if (ovf[2] !== 1'b1) begin
            failures++;
            $display("FAIL sat_ovf_set got=%b exp=%b", ovf[2], 1'b1);
        end
        tick();
        ovf_clr = 4'b0100;
        tick();
        ovf_clr = '0;
        checks++;
        if (ovf[2] !== 1'b1) begin
            failures++;
            $display("FAIL sat_set_beats_clr got=%b exp=%b", ovf[2], 1'b1);
        end
        inc_en = '0;
        rd_sel = 2'd2;
        tick();
        checks++;
        if (rd_data !== 30'h3FFF_FFFF) begin
            failures++;
            $display("FAIL sat_value got=%h exp=%h", rd_data, 30'h3FFF_FFFF);
        end
        write_ch(2'd2, 30'd5);
        checks++;
        if (ovf[2] !== 1'b1) begin
            failures++;
            $display("FAIL sat_write_keeps_ovf got=%b exp=%b", ovf[2], 1'b1);
        end
        tick();
        checks++;
        if (rd_data !== 30'd5) begin
            failures++;
            $display("FAIL sat_written_value got=%h exp=%h", rd_data, 30'd5);
        end
        ovf_clr = 4'b0100;
        tick();
        ovf_clr = '0;
        checks++;
        if (ovf[2] !== 1'b0) begin
            failures++;
            $display("FAIL sat_ovf_clr got=%b exp=%b", ovf[2], 1'b0);
        end
    endtask

    task automatic test_collision();
        inc_en = 4'b1000;
        rd_sel = 2'd3;
        write_ch(2'd3, 30'h123);
        inc_en = '0;
        tick();
        checks++;
        if (rd_data !== 30'h123) begin
            failures++;
            $display("FAIL collision_write_wins got=%h exp=%h", rd_data, 30'h123);
        end
        inc_en = 4'b1000;
        tick();
        inc_en = '0;
        tick();
        checks++;
        if (rd_data !== 30'h124) begin
            failures++;
            $display("FAIL collision_next_inc got=%h exp=%h", rd_data, 30'h124);
        end
        // Read register captures the pre-edge count during the write edge
        write_ch(2'd3, 30'h55);
        checks++;
        if (rd_data !== 30'h124) begin
            failures++;
            $display("FAIL raw_same_edge got=%h exp=%h", rd_data, 30'h124);
        end
        tick();
        checks++;
        if (rd_data !== 30'h55) begin
            failures++;
            $display("FAIL raw_next_cycle got=%h exp=%h", rd_data, 30'h55);
        end
    endtask

    task automatic test_parallel();
        pulse_reset();
        inc_en = 4'b1111;
        repeat (10) tick();
        inc_en = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rd_sel = SEL_W'(i);
            tick();
            checks++;
            if (rd_data !== 30'd10) begin
                failures++;
                $display("FAIL parallel_ch%0d got=%h exp=%h", i, rd_data, 30'd10);
            end
        end
        checks++;
        if (ovf !== 4'b0000) begin
            failures++;
            $display("FAIL parallel_ovf got=%b exp=%b", ovf, 4'b0000);
        end
    endtask

    task automatic test_reset_clears_ovf();
        sat_mode = 4'b0000;
        write_ch(2'd0, 30'h3FFF_FFFF);
        inc_en = 4'b0001;
        tick();
        inc_en = '0;
        checks++;
        if (ovf !== 4'b0001) begin
            failures++;
            $display("FAIL pre_reset_ovf got=%b exp=%b", ovf, 4'b0001);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (ovf !== 4'b0000) begin
            failures++;
            $display("FAIL reset_clears_ovf got=%b exp=%b", ovf, 4'b0000);
        end
        reset = 1'b1;
        tick();
    endtask

`ifdef COUNTER_BANK_IRQ_EN
    task automatic test_irq();
        irq_mask = 4'b0010;
        sat_mode = 4'b0000;
        write_ch(2'd0, 30'h3FFF_FFFF);
        inc_en = 4'b0001;
        tick();
        inc_en = '0;
        tick();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_masked_ch0 got=%b exp=%b", irq, 1'b0);
        end
        write_ch(2'd1, 30'h3FFF_FFFF);
        inc_en = 4'b0010;
        tick();
        inc_en = '0;
        checks++;
        if (irq !== 1'b0 || ovf[1] !== 1'b1) begin
            failures++;
            $display("FAIL irq_lag got irq=%b ovf1=%b exp irq=0 ovf1=1", irq, ovf[1]);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_ch1 got=%b exp=%b", irq, 1'b1);
        end
    endtask
`endif

    initial begin
        reset    = 1'b0;
        inc_en   = '0;
        sat_mode = '0;
        wr_en    = 1'b0;
        wr_sel   = '0;
        wr_data  = '0;
        rd_sel   = '0;
        ovf_clr  = '0;
`ifdef COUNTER_BANK_IRQ_EN
        irq_mask = '0;
`endif
        test_reset();
        test_wrap();
        test_saturate();
        test_collision();
        test_parallel();
        test_reset_clears_ovf();
`ifdef COUNTER_BANK_IRQ_EN
        test_irq();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/incrementer_counter_bank.md
# incrementer_counter_bank

Bank of CHANNELS independent LEN-bit event counters built around the core incrementer, for hardware performance and event counting in the phoeniX core. Each channel increments on its own strobe and can be written by software. Each channel wraps or saturates per a mode bit and records sticky overflow. Reads are registered so the bank can sit behind the CSR read path without lengthening it.

## Interface
- LEN, 30, counter width in bits (≥ 2)
- CHANNELS, 4, number of counters (1..16)
- SEL_W, $clog2(CHANNELS) (min 1), select width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- inc_en  in  CHANNELS  per-channel increment strobe, one count per asserted cycle
- sat_mode  in  CHANNELS  per-channel mode: 0 = wrap, 1 = saturate
- wr_en  in  1  write strobe
- wr_sel  in  SEL_W  channel to write
- wr_data  in  LEN  value to load
- rd_sel  in  SEL_W  channel to read
- rd_data  out  LEN  registered read data
- ovf  out  CHANNELS  sticky overflow flags
- ovf_clr  in  CHANNELS  per-channel overflow clear

## Operation
- Per-channel next value, priority order:
  - wr_en with wr_sel = ch: count ← wr_data, no increment that cycle.
  - Otherwise, inc_en[ch] with count < all-ones: count ← count + 1.
  - Otherwise, inc_en[ch] with count = all-ones: wrap mode → 0; saturate mode → hold all-ones. ovf[ch] ← 1 in both modes.
  - Otherwise: hold.
- Arithmetic is unsigned modulo 2^LEN. There is no carry out other than ovf.
- ovf[ch]:
  - Set on an overflow event.
  - Cleared by ovf_clr[ch].
  - Set wins over a simultaneous clear.
  - A write does not affect ovf.
- Writes with wr_sel ≥ CHANNELS are ignored.
- rd_data ← count[rd_sel] as held before the edge; it excludes any same-edge update. When rd_sel ≥ CHANNELS, rd_data ← 0.
- Reset (asserted at any time, including mid-count): all counts = 0, ovf = 0, rd_data = 0, immediately and asynchronously. Release is synchronised externally.

## Timing
- Increment latency: 1 cycle; the count updates at the edge where inc_en is sampled.
- Write latency: 1 cycle.
- Read latency: 1 cycle. rd_data at edge N+1 reflects count after edge N.
- Read-after-write to the same channel in consecutive cycles returns the new value.
- The saturate-mode hold of all-ones repeats every cycle inc_en stays high, and ovf stays set.
- No handshake; every strobe is single-cycle and level-sampled.

## Configuration
- COUNTER_BANK_IRQ_EN defined:
  - Adds input irq_mask [CHANNELS] and output irq [1].
  - irq is a register equal to |(ovf & irq_mask), updated every cycle (one cycle after ovf), reset 0.
- COUNTER_BANK_IRQ_EN undefined: the ports are absent and there is no interrupt logic. Counter behaviour is identical in both builds.

## Structure
- Package incrementer_pkg:
  - Default LEN.
  - Mode constants CNT_WRAP = 0 and CNT_SAT = 1.
  - A function returning the all-ones constant for a given LEN.
- Sub-module incrementer_channel holds one counter, its ovf flag and the priority logic. The top instantiates it CHANNELS times and adds the read mux, read register and optional irq.

## Test plan
- Reset mid-count: count channel 0 to 5, assert reset → all counts, ovf and rd_data read 0 within the same cycle.
- Wrap, LEN = 30: write 0x3FFF_FFFE to ch1 in wrap mode, inc 2 cycles → ch1 = 0x0000_0000 and ovf[1] = 1. ovf_clr[1] → ovf[1] = 0.
- Saturate: ch2 in saturate mode, write 0x3FFF_FFFF, inc 3 cycles → ch2 stays 0x3FFF_FFFF and ovf[2] = 1. Simultaneous ovf_clr and overflow → ovf[2] remains 1.
- Write versus increment collision: wr_en to ch3 with 0x123 while inc_en[3] = 1 → ch3 = 0x123, not 0x124. Next cycle, inc → 0x124.
- Parallel channels: inc_en = 4'b1111 for 10 cycles from reset → each channel reads 10. rd_sel sweep 0..3 gives rd_data 10 one cycle after each select.
- IRQ build: irq_mask = 4'b0010, overflow ch1 → irq = 1 one cycle after ovf[1]. Overflow only ch0 → irq stays 0.
